alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//  16-bit add/subtract unit of the simple processor datapath.
//  - Combines operand registers Rx and Ry into a result that is written back through the bus.
//  - Result is combinational (zero latency).
//  - A registered status-flag bank captures Z/N/C/V for later branch or status use.
// PARAMETERS
//  WIDTH  16  datapath width in bits; all operand/result ports scale with it
// PORTS
//  CLOCK_50  in   1      system clock, rising edge active
//  reset     in   1      asynchronous, active-high reset of flag registers
//  rx        in   WIDTH  operand A (minuend for subtract)
//  ry        in   WIDTH  operand B (subtrahend for subtract)
//  addsub    in   1      0 = rx+ry, 1 = rx-ry
//  flag_we   in   1      1 = capture current flags on next rising clock edge
//  results   out  WIDTH  arithmetic result, combinational
//  flags     out  4      registered {Z,N,C,V}
// BEHAVIOUR
//  - Arithmetic: sum = rx + (addsub ? ~ry : ry) + addsub, computed WIDTH+1 wide.
//    - results = sum[WIDTH-1:0]; wraps modulo 2^WIDTH unless ALU_SATURATE_EN.
//    - results settles in the same delta as input change; no clock involvement.
//  - Flag definitions (computed combinationally from the final results value):
//    - Z = (results == 0).
//    - N = results[WIDTH-1].
//    - C = sum[WIDTH]. For subtract, C=1 means no borrow (rx >= ry unsigned).
//    - V = signed overflow: operands of the effective addition share a sign
//      and sum[WIDTH-1] differs from that sign.
//  - Flag register:
//    - flags <= {Z,N,C,V} on posedge CLOCK_50 when flag_we=1; otherwise holds.
//    - Latency one cycle from inputs to flags.
//  - Reset: reset=1 forces flags to 4'b0000 immediately, independent of clock.
//    - Reset during a flag_we cycle wins; flags stay 0 while reset is asserted.
//    - results is unaffected by reset and always reflects rx/ry/addsub.
//  - Boundaries: 0-1 -> 0xFFFF, C=0, N=1. 0xFFFF+1 -> 0x0000, C=1, Z=1.
//    0x7FFF+1 -> 0x8000, V=1.
//  - No X propagation on defined inputs; no internal state other than flags.
// CONFIGURATION
//  ALU_SATURATE_EN defined:
//    - On signed overflow (V=1), results clamps to 0x7FFF (positive overflow)
//      or 0x8000 (negative overflow).
//    - V still reports 1; Z/N/C are computed from the clamped result (C from raw sum).
//  ALU_SATURATE_EN undefined: plain two's-complement wrap-around as above.
// STRUCTURE
//  - Shared package alu_pkg:
//    - ALU_WIDTH = 16.
//    - Flag index constants FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0.
//    - Typedef alu_op_t (ADD=0, SUB=1).
//  - One sub-module, alu_addsub_core:
//    - Purely combinational.
//    - Produces sum, carry and overflow from rx/ry/addsub.
//  - Top alu adds the saturation mux, flag derivation and the flag register.
// TESTING
//  - rx=10, ry=10, addsub=0 -> results=20; after flag_we edge, flags=0000.
//  - rx=20, ry=10, addsub=1 -> results=10; flags after edge C=1, Z=0.
//  - rx=30, ry=10, addsub=0 -> results=40; then rx=20, ry=20, addsub=1 -> results=0,
//    flags Z=1, C=1.
//  - rx=0x7FFF, ry=1, addsub=0 -> results=0x8000 with V=1, N=1
//    (0x7FFF with ALU_SATURATE_EN).
//  - rx=0, ry=1, addsub=1 -> results=0xFFFF, N=1, C=0.
//  - Assert reset mid-cycle with flag_we=1 -> flags=0000 immediately;
//    flag_we=0 across edges -> flags hold.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the add/subtract ALU: width, flag bit positions and operation encoding.
package alu_pkg;
  localparam int ALU_WIDTH = 16;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } alu_op_t;
endpackage

// File: rtl/alu_addsub_core.sv
// Combinational add/subtract core: produces the raw sum, carry-out and signed overflow.
module alu_addsub_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] rx,
  input  logic [WIDTH-1:0] ry,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             pos_overflow
);
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;

  // Subtract is rx + ~ry + 1, so the carry-in doubles as the subtract select.
  assign w_b   = sub ? ~ry : ry;
  assign w_sum = {1'b0, rx} + {1'b0, w_b} + {{WIDTH{1'b0}}, sub};

  assign sum      = w_sum[WIDTH-1:0];
  assign carry    = w_sum[WIDTH];
  assign overflow = (rx[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != rx[WIDTH-1]);
  // Two non-negative operands can only overflow upwards.
  assign pos_overflow = overflow && !rx[WIDTH-1];
endmodule

// File: rtl/alu.sv
// 16-bit add/subtract ALU with combinational result and registered {Z,N,C,V} flags.
// Optional feature: define ALU_SATURATE_EN to clamp the result on signed overflow.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [WIDTH-1:0] rx,
  input  logic [WIDTH-1:0] ry,
  input  logic             addsub,
  input  logic             flag_we,
  output logic [WIDTH-1:0] results,
  output logic [3:0]       flags
);
  alu_op_t          w_op;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_overflow;
  logic             w_pos_overflow;
  logic [WIDTH-1:0] w_result;
  logic [3:0]       w_flags;
  logic [3:0]       r_flags;

  assign w_op = alu_op_t'(addsub);

  alu_addsub_core #(.WIDTH(WIDTH)) u_core (
    .rx           (rx),
    .ry           (ry),
    .sub          (w_op == SUB),
    .sum          (w_sum),
    .carry        (w_carry),
    .overflow     (w_overflow),
    .pos_overflow (w_pos_overflow)
  );

`ifdef ALU_SATURATE_EN
  always_comb begin
    w_result = w_sum;
    if (w_overflow)
      w_result = w_pos_overflow ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
  end
`else
  logic w_unused;
  assign w_unused = w_pos_overflow;
  assign w_result = w_sum;
`endif

  assign results = w_result;

  // Z and N follow the final (possibly clamped) result; C always comes from the raw sum.
  always_comb begin
    w_flags         = 4'b0000;
    w_flags[FLAG_Z] = (w_result == '0);
    w_flags[FLAG_N] = w_result[WIDTH-1];
    w_flags[FLAG_C] = w_carry;
    w_flags[FLAG_V] = w_overflow;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)
      r_flags <= 4'b0000;
    else if (flag_we)
      r_flags <= w_flags;
  end

  assign flags = r_flags;
endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the add/subtract ALU (honours ALU_SATURATE_EN).
module tb_alu;
  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic [15:0] rx;
  logic [15:0] ry;
  logic        addsub;
  logic        flag_we;
  logic [15:0] results;
  logic [3:0]  flags;

  int n_pass  = 0;
  int n_total = 0;

  alu dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .rx       (rx),
    .ry       (ry),
    .addsub   (addsub),
    .flag_we  (flag_we),
    .results  (results),
    .flags    (flags)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    $display("check %-14s observed=0x%04h expected=0x%04h", tag, obs, exp);
  endtask

  // Apply one operation on the falling edge, check the combinational result,
  // then capture flags on the next rising edge and check them.
  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                    input logic sub, input logic [15:0] exp_res, input logic [3:0] exp_flags);
    @(negedge CLOCK_50);
    rx = a; ry = b; addsub = sub; flag_we = 1'b1;
    #1;
    check({tag, "_res"}, results, exp_res);
    @(posedge CLOCK_50);
    #1;
    check({tag, "_flg"}, {12'h000, flags}, {12'h000, exp_flags});
  endtask

  initial begin
    reset = 1'b1; rx = '0; ry = '0; addsub = 1'b0; flag_we = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    check("reset_flags", {12'h000, flags}, 16'h0000);
    @(negedge CLOCK_50);
    reset = 1'b0;

    op("add_10_10", 16'd10, 16'd10, 1'b0, 16'd20, 4'b0000);
    op("sub_20_10", 16'd20, 16'd10, 1'b1, 16'd10, 4'b0010);
    op("add_30_10", 16'd30, 16'd10, 1'b0, 16'd40, 4'b0000);
    op("sub_20_20", 16'd20, 16'd20, 1'b1, 16'd0,  4'b1010);
`ifdef ALU_SATURATE_EN
    op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 4'b0001);
`else
    op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0101);
`endif
    op("sub_0_1",    16'h0000, 16'h0001, 1'b1, 16'hFFFF, 4'b0100);
    op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b1010);
`ifdef ALU_SATURATE_EN
    op("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 16'h8000, 4'b0111);
`else
    op("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b0011);
`endif

    // Flags must hold across edges while flag_we is low.
    @(negedge CLOCK_50);
    flag_we = 1'b0; rx = 16'd1; ry = 16'd1; addsub = 1'b0;
    #1;
    check("hold_res", results, 16'd2);
    repeat (2) @(posedge CLOCK_50);
    #1;
`ifdef ALU_SATURATE_EN
    check("hold_flg", {12'h000, flags}, 16'h0007);
`else
    check("hold_flg", {12'h000, flags}, 16'h0003);
`endif

    // Mid-cycle asynchronous reset while flag_we is high.
    flag_we = 1'b1; rx = 16'h0000; ry = 16'h0001; addsub = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    check("rst_async", {12'h000, flags}, 16'h0000);
    check("rst_res", results, 16'hFFFF);
    @(posedge CLOCK_50);
    #1;
    check("rst_we_edge", {12'h000, flags}, 16'h0000);

    @(negedge CLOCK_50);
    reset = 1'b0; flag_we = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    check("post_rst_hold", {12'h000, flags}, 16'h0000);

    op("recapture", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 4'b0100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
